mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one memory port between an instruction-fetch requester and a
// data-memory requester. A request seen in IDLE is granted on the next
// rising edge. The granted address, write enable and mux select are
// registered and stay frozen until the access completes (mem_ready_i) or
// is aborted by the wait-timeout.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined   : on simultaneous requests, the requester
//                                   not served last wins.
//                       undefined : on simultaneous requests, data wins.
//
// Parameters:
//   TIMEOUT      grant cycles without mem_ready_i before aborting (0 = never)
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   if_req_i     fetch request           if_addr_i  fetch address
//   dm_req_i     data request            dm_addr_i  data address
//   dm_we_i      data write enable
//   mem_ready_i  completion of the current shared-port access
//   mem_valid_o  shared port access active
//   mem_addr_o   registered address of the granted requester
//   mem_we_o     registered write enable (0 for fetch grants)
//   sel_o        address mux select: 0 = fetch, 1 = data
//   if_done_o    one-cycle completion pulse to the fetch requester
//   dm_done_o    one-cycle completion pulse to the data requester
//   err_o        timeout abort pulse, high during the last grant cycle
//   busy_o       high whenever the arbiter is not IDLE
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        dm_req_i,
  input  logic [31:0] dm_addr_i,
  input  logic        dm_we_i,
  input  logic        mem_ready_i,
  output logic        mem_valid_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic        sel_o,
  output logic        if_done_o,
  output logic        dm_done_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GNT_IF = 2'd1;
  localparam logic [1:0] ST_GNT_DM = 2'd2;

  // Wide enough to hold TIMEOUT-1, the last value the counter ever holds.
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [1:0]    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic          sel_q, sel_d;
  logic          if_done_q, if_done_d;
  logic          dm_done_q, dm_done_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          pick_dm;
  logic          timeout_hit;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = data was served last, 0 = fetch was served last.
  logic last_q, last_d;

  // The requester not served last wins a tie.
  assign pick_dm = dm_req_i && (!if_req_i || !last_q);
`else
  assign pick_dm = dm_req_i;
`endif

  // The abort fires in the cycle the wait count reaches TIMEOUT; a
  // mem_ready_i in that same cycle wins and counts as completion.
  assign timeout_hit = (TIMEOUT != 0) && (state_q != ST_IDLE) && !mem_ready_i &&
                       (wait_q == CW'(TIMEOUT - 1));

  // NOTE: every variable gets a hold/default value before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    sel_d     = sel_q;
    wait_d    = wait_q;
    if_done_d = 1'b0;
    dm_done_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d    = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // mem_ready_i is deliberately not looked at here.
        if (if_req_i || dm_req_i) begin
          state_d = pick_dm ? ST_GNT_DM : ST_GNT_IF;
          addr_d  = pick_dm ? dm_addr_i : if_addr_i;
          we_d    = pick_dm && dm_we_i;
          sel_d   = pick_dm;
          wait_d  = '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = pick_dm;
`endif
        end
      end
      ST_GNT_IF, ST_GNT_DM: begin
        // Requester inputs are ignored until the access ends.
        if (mem_ready_i) begin
          state_d   = ST_IDLE;
          if_done_d = (state_q == ST_GNT_IF);
          dm_done_d = (state_q == ST_GNT_DM);
          wait_d    = '0;
        end else if (timeout_hit) begin
          state_d = ST_IDLE;
          wait_d  = '0;
        end else if (TIMEOUT != 0) begin
          wait_d = wait_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      sel_q     <= 1'b0;
      wait_q    <= '0;
      if_done_q <= 1'b0;
      dm_done_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      wait_q    <= wait_d;
      if_done_q <= if_done_d;
      dm_done_q <= dm_done_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q    <= last_d;
`endif
    end
  end

  assign mem_valid_o = (state_q != ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign mem_addr_o  = addr_q;
  assign mem_we_o    = we_q;
  assign sel_o       = sel_q;
  assign if_done_o   = if_done_q;
  assign dm_done_o   = dm_done_q;
  assign err_o       = timeout_hit;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter (TIMEOUT = 16). A transaction-level
// model (who owns the port, how many grant cycles have elapsed) predicts
// the outputs for every cycle; one negedge process compares them. Literal
// expectations pin grant order, pulse counts, timeout position and reset.
// Inputs change 2 time units after each rising edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int TO = 16;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_we, mem_ready;
  logic [31:0] if_addr, dm_addr;
  logic        mem_valid, mem_we, sel, if_done, dm_done, err, busy;
  logic [31:0] mem_addr;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .dm_req_i(dm_req), .dm_addr_i(dm_addr), .dm_we_i(dm_we),
    .mem_ready_i(mem_ready),
    .mem_valid_o(mem_valid), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .sel_o(sel), .if_done_o(if_done), .dm_done_o(dm_done),
    .err_o(err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // owner: 0 = port free, 1 = fetch, 2 = data. cyc = 1-based grant cycle.
  int          m_owner;
  int          m_cyc;
  logic [31:0] m_addr;
  logic        m_we, m_sel, m_last, m_if_done, m_dm_done;

  task automatic model_edge();
    bit dm_wins;
    m_if_done = 1'b0;
    m_dm_done = 1'b0;
    if (m_owner == 0) begin
      if (if_req || dm_req) begin
        if (if_req && dm_req) dm_wins = RR ? !m_last : 1'b1;
        else                  dm_wins = dm_req;
        m_owner = dm_wins ? 2 : 1;
        m_addr  = dm_wins ? dm_addr : if_addr;
        m_we    = dm_wins ? dm_we : 1'b0;
        m_sel   = dm_wins;
        m_last  = dm_wins;
        m_cyc   = 1;
      end
    end else if (mem_ready) begin
      m_if_done = (m_owner == 1);
      m_dm_done = (m_owner == 2);
      m_owner   = 0;
    end else if (TO != 0 && m_cyc == TO) begin
      m_owner = 0;
    end else begin
      m_cyc++;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = 0; m_cyc = 0; m_addr = '0; m_we = 1'b0; m_sel = 1'b0;
      m_last = 1'b1; m_if_done = 1'b0; m_dm_done = 1'b0;
    end else begin
      model_edge();
    end
  end

  // ---------------- compare + observation process ----------------
  logic        prev_valid = 1'b0, prev_err = 1'b0;
  int          cyc_no = 0, grant_len = 0, err_at = -1;
  logic        busy_after_err = 1'bx;
  int          cnt_if = 0, cnt_dm = 0, cnt_err = 0;
  logic        log_sel[$];
  logic [31:0] log_addr[$];
  int          log_cyc[$];

  always @(negedge clk) begin
    logic exp_err;
    exp_err = (m_owner != 0) && !mem_ready && (TO != 0) && (m_cyc == TO);
    check("mem_valid", 32'(mem_valid), 32'(m_owner != 0));
    check("busy",      32'(busy),      32'(m_owner != 0));
    check("sel",       32'(sel),       32'(m_sel));
    check("if_done",   32'(if_done),   32'(m_if_done));
    check("dm_done",   32'(dm_done),   32'(m_dm_done));
    check("err",       32'(err),       32'(exp_err));
    if (m_owner != 0) begin
      check("mem_addr", mem_addr,     m_addr);
      check("mem_we",   32'(mem_we),  32'(m_we));
    end
    if (mem_valid && !prev_valid) begin
      log_sel.push_back(sel);
      log_addr.push_back(mem_addr);
      log_cyc.push_back(cyc_no);
      grant_len = 0;
    end
    if (mem_valid) grant_len++;
    if (prev_err) busy_after_err = busy;
    if (err) begin cnt_err++; err_at = grant_len; end
    if (if_done) cnt_if++;
    if (dm_done) cnt_dm++;
    prev_err   = err;
    prev_valid = mem_valid;
    cyc_no++;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_log(input int k, input logic exp_sel, input logic [31:0] exp_addr);
    if (log_sel.size() <= k) begin
      check($sformatf("grant%0d_present", k), 32'(log_sel.size()), 32'(k + 1));
    end else begin
      check($sformatf("grant%0d_sel", k),  32'(log_sel[k]), 32'(exp_sel));
      check($sformatf("grant%0d_addr", k), log_addr[k],     exp_addr);
    end
  endtask

  initial begin
    int b_if, b_dm, b_err, b_log;
    rst_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
    if_addr = '0; dm_addr = '0;
    tick(2);
    check("reset_valid", 32'(mem_valid), 32'd0);
    check("reset_sel",   32'(sel),       32'd0);
    check("reset_addr",  mem_addr,       32'd0);
    rst_n = 1'b1;
    tick(1);

    // Fetch access, ready in the third grant cycle; inputs wiggle mid-grant.
    if_req = 1'b1; if_addr = 32'h0040_0000;
    tick(1);
    if_req = 1'b0; if_addr = 32'hDEAD_BEEF;
    tick(2);
    mem_ready = 1'b1;
    tick(1);
    mem_ready = 1'b0;
    tick(2);
    check_log(0, 1'b0, 32'h0040_0000);
    check("A_if_done_cnt", 32'(cnt_if), 32'd1);
    check("A_dm_done_cnt", 32'(cnt_dm), 32'd0);

    // Store access; dm_we/dm_addr change mid-grant and must be ignored.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h1001_0004;
    tick(1);
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0BAD_0BAD;
    tick(1);
    mem_ready = 1'b1;
    tick(1);
    mem_ready = 1'b0;
    tick(2);
    check_log(1, 1'b1, 32'h1001_0004);
    check("B_dm_done_cnt", 32'(cnt_dm), 32'd1);
    check("B_if_done_cnt", 32'(cnt_if), 32'd1);

    // mem_ready while IDLE does nothing.
    b_log = log_sel.size();
    mem_ready = 1'b1;
    tick(3);
    mem_ready = 1'b0;
    tick(1);
    check("idle_ready_grants", 32'(log_sel.size()), 32'(b_log));
    check("idle_ready_done",   32'(cnt_if + cnt_dm), 32'd2);

    // Both requesters held for four accesses, ready always high.
    b_if = cnt_if; b_dm = cnt_dm;
    if_req = 1'b1; if_addr = 32'h0000_1000;
    dm_req = 1'b1; dm_addr = 32'h2000_0000; dm_we = 1'b0;
    mem_ready = 1'b1;
    tick(7);
    if_req = 1'b0; dm_req = 1'b0;
    tick(1);
    mem_ready = 1'b0;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      logic exp_s;
      exp_s = RR ? logic'(i % 2) : 1'b1;
      check_log(2 + i, exp_s, exp_s ? 32'h2000_0000 : 32'h0000_1000);
    end
    for (int i = 3; i <= 5; i++) begin
      if (log_cyc.size() > i) check($sformatf("gap%0d", i), 32'(log_cyc[i] - log_cyc[i-1]), 32'd2);
      else                    check($sformatf("gap%0d_present", i), 32'(log_cyc.size()), 32'(i + 1));
    end
    check("C_if_done_delta", 32'(cnt_if - b_if), RR ? 32'd2 : 32'd0);
    check("C_dm_done_delta", 32'(cnt_dm - b_dm), RR ? 32'd2 : 32'd4);

    // Timeout: ready never comes.
    b_if = cnt_if; b_err = cnt_err;
    if_req = 1'b1; if_addr = 32'h0000_2000;
    tick(1);
    if_req = 1'b0;
    tick(20);
    check("D_err_cnt",     32'(cnt_err - b_err), 32'd1);
    check("D_err_at",      32'(err_at),          32'd16);
    check("D_busy_after",  32'(busy_after_err),  32'd0);
    check("D_no_done",     32'(cnt_if - b_if),   32'd0);

    // Ready arrives exactly in the 16th grant cycle: completion, not error.
    b_dm = cnt_dm; b_err = cnt_err;
    dm_req = 1'b1; dm_addr = 32'h3000_0000;
    tick(1);
    dm_req = 1'b0;
    tick(15);
    mem_ready = 1'b1;
    tick(1);
    mem_ready = 1'b0;
    tick(2);
    check("E_dm_done",  32'(cnt_dm - b_dm),   32'd1);
    check("E_no_err",   32'(cnt_err - b_err), 32'd0);

    // Reset mid data grant, then only fetch requests.
    b_if = cnt_if; b_dm = cnt_dm; b_err = cnt_err;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h4000_0000;
    tick(1);
    dm_req = 1'b0; dm_we = 1'b0;
    tick(1);
    #1 rst_n = 1'b0;
    #1;
    check("F_rst_valid", 32'(mem_valid), 32'd0);
    check("F_rst_busy",  32'(busy),      32'd0);
    check("F_rst_sel",   32'(sel),       32'd0);
    check("F_rst_we",    32'(mem_we),    32'd0);
    check("F_rst_addr",  mem_addr,       32'd0);
    tick(2);
    if_req = 1'b1; if_addr = 32'h0050_0000;
    rst_n = 1'b1;
    b_log = log_sel.size();
    tick(1);
    if_req = 1'b0;
    mem_ready = 1'b1;
    tick(1);
    mem_ready = 1'b0;
    tick(2);
    check_log(b_log, 1'b0, 32'h0050_0000);
    check("F_if_done",  32'(cnt_if - b_if),   32'd1);
    check("F_no_dm",    32'(cnt_dm - b_dm),   32'd0);
    check("F_no_err",   32'(cnt_err - b_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
